// File: rtl/ahb_slave_seq.sv
// -----------------------------------------------------------------------------
// ahb_slave_seq
//
// Sequencer for an oversampled AHB-Lite slave port. Runs in the fast clk
// domain and uses one-clk HCLK edge pulses to decide when to sample the bus
// (HCLK_fall, mid-cycle) and when to update the AHB response outputs. Each AHB
// single transfer becomes one req/ack transaction on a local register port.
// Wait states are held while the local side works; misaligned or out-of-range
// addresses and local timeouts produce the AHB two-cycle ERROR response.
//
// Ports:
//   clk, n_rst           fast clock, asynchronous active-low reset
//   HCLK_rise/HCLK_fall  one-clk pulses per detected HCLK edge
//   HSEL, HTRANS, HWRITE, HREADY, HADDR, HWDATA   AHB slave inputs
//   HREADYOUT, HRESP, HRDATA                      AHB slave outputs
//   reg_req, reg_write, reg_addr, reg_wdata       local request (level)
//   reg_ack, reg_rdata                            local completion pulse/data
// -----------------------------------------------------------------------------
module ahb_slave_seq #(
   parameter int ADDR_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int TIMEOUT  = 4
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              HCLK_rise,
   input  logic              HCLK_fall,
   input  logic              HSEL,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic              HREADY,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [31:0]       HWDATA,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   output logic              reg_req,
   output logic              reg_write,
   output logic [ADDR_W-3:0] reg_addr,
   output logic [31:0]       reg_wdata,
   input  logic              reg_ack,
   input  logic [31:0]       reg_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int IDX_W = ADDR_W - 2;

   typedef enum logic [2:0] {
      IDLE, PEND, LOCAL, RESP, ERR0, ERR1, ERR2
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] haddr_q;
   logic              hwrite_q;
   logic [31:0]       rdata_q;
   logic              hreadyout_q;
   logic              hresp_q;
   logic [31:0]       hrdata_q;
   logic              reg_req_q;
   logic              reg_write_q;
   logic [IDX_W-1:0]  reg_addr_q;
   logic [31:0]       reg_wdata_q;

   // Only HTRANS[1] matters: NONSEQ and SEQ are treated alike for singles.
   logic unused_htrans0;
   assign unused_htrans0 = HTRANS[0];

   logic             addr_valid;
   logic [IDX_W-1:0] word_idx;
   logic             dec_err;

   assign addr_valid = HSEL & HTRANS[1];
   assign word_idx   = haddr_q[ADDR_W-1:2];
   assign dec_err    = (haddr_q[1:0] != 2'b00) || (32'(word_idx) >= 32'(NUM_REGS));

   // NOTE: every register in this block uses <= so all updates in a clk see
   // the same pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         rdata_q     <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         hrdata_q    <= '0;
         reg_req_q   <= 1'b0;
         reg_write_q <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (HCLK_fall && addr_valid && HREADY) begin
                  haddr_q  <= HADDR;
                  hwrite_q <= HWRITE;
                  state_q  <= PEND;
               end
            end

            // This fall pulse is the data phase of the accepted transfer.
            PEND: begin
               if (HCLK_fall) begin
                  hreadyout_q <= 1'b0;
                  if (dec_err) begin
                     hresp_q <= 1'b1;
                     state_q <= ERR1;
                  end else begin
                     if (hwrite_q) begin
                        reg_wdata_q <= HWDATA;
                     end
                     reg_write_q <= hwrite_q;
                     reg_addr_q  <= word_idx;
                     reg_req_q   <= 1'b1;
                     cnt_q       <= '0;
                     state_q     <= LOCAL;
                  end
               end
            end

            // Fall pulses are deliberately ignored here: a fall coinciding with
            // reg_ack is not consumed, RESP waits for the next one.
            LOCAL: begin
               if (reg_ack) begin
                  reg_req_q <= 1'b0;
                  if (!reg_write_q) begin
                     rdata_q <= reg_rdata;
                  end
                  state_q <= RESP;
               end else if (HCLK_rise) begin
                  if (cnt_q != CNT_W'(TIMEOUT)) begin
                     cnt_q <= cnt_q + 1'b1;
                  end
                  if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                     reg_req_q <= 1'b0;
                     state_q   <= ERR0;
                  end
               end
            end

            // Our own HREADYOUT rises on this fall, so the bus is ready here.
            RESP: begin
               if (HCLK_fall) begin
                  hreadyout_q <= 1'b1;
                  if (!reg_write_q) begin
                     hrdata_q <= rdata_q;
                  end
                  if (addr_valid) begin
                     haddr_q  <= HADDR;
                     hwrite_q <= HWRITE;
                     state_q  <= PEND;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end

            ERR0: begin
               if (HCLK_fall) begin
                  hresp_q <= 1'b1;
                  state_q <= ERR1;
               end
            end

            ERR1: begin
               if (HCLK_fall) begin
                  hreadyout_q <= 1'b1;
                  state_q     <= ERR2;
               end
            end

            ERR2: begin
               if (HCLK_fall) begin
                  hresp_q <= 1'b0;
                  if (addr_valid && HREADY) begin
                     haddr_q  <= HADDR;
                     hwrite_q <= HWRITE;
                     state_q  <= PEND;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end

            // NOTE: the unused 3-bit encoding recovers to IDLE instead of
            // leaving the FSM stuck in an undefined state.
            default: state_q <= IDLE;
         endcase
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;
   assign reg_req   = reg_req_q;
   assign reg_write = reg_write_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_ahb_slave_seq.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_seq
//
// Bench for ahb_slave_seq. A single-process loop (tick) advances one clk at a
// time on the falling clk edge: it generates the HCLK edge pulses, acts as a
// pipelined AHB master, acts as the local register responder, and compares DUT
// outputs against expectations queued when each transfer is issued.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_slave_seq;

   localparam int ADDR_W   = 8;
   localparam int NUM_REGS = 16;
   localparam int TIMEOUT  = 4;
   localparam int HPER     = 8;    // clk cycles per HCLK cycle

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        HCLK_rise = 1'b0;
   logic        HCLK_fall = 1'b0;
   logic        HSEL = 1'b0;
   logic [1:0]  HTRANS = 2'b00;
   logic        HWRITE = 1'b0;
   logic        HREADY = 1'b1;
   logic [7:0]  HADDR = '0;
   logic [31:0] HWDATA = '0;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        reg_req;
   logic        reg_write;
   logic [5:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_ack = 1'b0;
   logic [31:0] reg_rdata = '0;

   ahb_slave_seq #(
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .HCLK_rise (HCLK_rise),
      .HCLK_fall (HCLK_fall),
      .HSEL      (HSEL),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HREADY    (HREADY),
      .HADDR     (HADDR),
      .HWDATA    (HWDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .reg_req   (reg_req),
      .reg_write (reg_write),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_ack   (reg_ack),
      .reg_rdata (reg_rdata)
   );

   always #5 clk = ~clk;

   // ack_delay >= 0: ack that many clk after reg_req is first seen.
   // ack_rise  >  0: ack in the same clk as that numbered HCLK_rise.
   // Neither set: no ack, the transfer must time out.
   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_delay;
      int          ack_rise;
      int          waits;      // expected wait-state rises, -1 = not checked
   } xfer_t;

   typedef struct {
      logic        wr;
      logic [5:0]  idx;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          ack_delay;
      int          ack_rise;
   } req_t;

   typedef struct {
      logic        err;
      logic [31:0] hrdata;
      int          waits;
   } resp_t;

   xfer_t stim_q[$];
   req_t  req_q[$];
   resp_t resp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   int          phase = HPER - 1;
   logic        ap_valid = 1'b0;
   logic [31:0] ap_wdata = '0;
   logic        dp_valid = 1'b0;
   logic        dp_err_seen = 1'b0;
   int          dp_waits = 0;
   logic [31:0] model_hrdata = '0;

   logic prev_req = 1'b0;
   logic req_active = 1'b0;
   logic acked = 1'b0;
   int   req_age = 0;
   int   ticks_since_ack = 0;
   int   ticks_since_rise = 0;
   int   rises_in_req = 0;
   req_t cur_req;

   function automatic xfer_t mk(input logic wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int ack_delay, input int ack_rise, input int waits);
      xfer_t x;
      x.wr = wr; x.addr = addr; x.wdata = wdata; x.rdata = rdata;
      x.ack_delay = ack_delay; x.ack_rise = ack_rise; x.waits = waits;
      return x;
   endfunction

   function automatic logic decode_err(input logic [7:0] a);
      return (a[1:0] != 2'b00) || (a[7:2] >= 6'(NUM_REGS));
   endfunction

   // Master behaviour at an HCLK rising edge (DUT sees the rise next posedge).
   task automatic master_rise();
      xfer_t x;
      resp_t e;
      req_t  r;
      logic  err;
      if (!dp_valid) begin
         vectors++;
         if ({HREADYOUT, HRESP} !== 2'b10) begin
            miscompares++;
            $display("FAIL idle_bus: HREADYOUT=%b HRESP=%b, want 1/0", HREADYOUT, HRESP);
         end
      end
      if (HREADYOUT === 1'b1) begin
         if (dp_valid) begin
            vectors++;
            if (resp_q.size() == 0) begin
               miscompares++;
               $display("FAIL resp_unexpected: completion with HRESP=%b, want none queued", HRESP);
            end else begin
               e = resp_q.pop_front();
               if (HRESP !== e.err || dp_err_seen !== e.err || HRDATA !== e.hrdata ||
                   (e.waits >= 0 && dp_waits != e.waits)) begin
                  miscompares++;
                  $display("FAIL resp: HRESP=%b err_cycle=%b HRDATA=%h waits=%0d, want HRESP=%b err_cycle=%b HRDATA=%h waits=%0d",
                           HRESP, dp_err_seen, HRDATA, dp_waits, e.err, e.err, e.hrdata, e.waits);
               end
            end
         end
         dp_valid    = ap_valid;
         dp_waits    = 0;
         dp_err_seen = 1'b0;
         HWDATA      = ap_valid ? ap_wdata : 32'h0;
         if (stim_q.size() > 0) begin
            x = stim_q.pop_front();
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = x.wr; HADDR = x.addr;
            ap_valid = 1'b1;
            ap_wdata = x.wdata;
            err = decode_err(x.addr) || (x.ack_delay < 0 && x.ack_rise == 0);
            if (!decode_err(x.addr)) begin
               r.wr = x.wr; r.idx = x.addr[7:2]; r.wdata = x.wdata; r.rdata = x.rdata;
               r.ack_delay = x.ack_delay; r.ack_rise = x.ack_rise;
               req_q.push_back(r);
            end
            if (!err && !x.wr) model_hrdata = x.rdata;
            e.err = err; e.hrdata = model_hrdata; e.waits = x.waits;
            resp_q.push_back(e);
         end else begin
            HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0;
            ap_valid = 1'b0;
         end
      end else if (dp_valid) begin
         dp_waits++;
         if (HRESP === 1'b1) dp_err_seen = 1'b1;
      end
   endtask

   task automatic tick();
      logic ok;
      @(negedge clk);
      if (req_active) begin
         req_age++; ticks_since_ack++; ticks_since_rise++;
      end
      if (reg_req === 1'b1 && !prev_req) begin
         vectors++;
         if (req_q.size() == 0) begin
            miscompares++;
            $display("FAIL req_unexpected: reg_req rose for addr %0d, want no request", reg_addr);
            cur_req.wr = reg_write; cur_req.idx = reg_addr; cur_req.wdata = reg_wdata;
            cur_req.rdata = '0; cur_req.ack_delay = -1; cur_req.ack_rise = 0;
         end else begin
            cur_req = req_q.pop_front();
            if (reg_write !== cur_req.wr || reg_addr !== cur_req.idx ||
                (cur_req.wr && reg_wdata !== cur_req.wdata)) begin
               miscompares++;
               $display("FAIL req: write=%b addr=%0d wdata=%h, want write=%b addr=%0d wdata=%h",
                        reg_write, reg_addr, reg_wdata, cur_req.wr, cur_req.idx, cur_req.wdata);
            end
         end
         req_active = 1'b1; acked = 1'b0; req_age = 0;
         rises_in_req = 0; ticks_since_rise = 0; ticks_since_ack = 0;
      end else if (reg_req === 1'b1) begin
         vectors++;
         if (reg_write !== cur_req.wr || reg_addr !== cur_req.idx ||
             (cur_req.wr && reg_wdata !== cur_req.wdata)) begin
            miscompares++;
            $display("FAIL req_stable: write=%b addr=%0d wdata=%h, want write=%b addr=%0d wdata=%h",
                     reg_write, reg_addr, reg_wdata, cur_req.wr, cur_req.idx, cur_req.wdata);
         end
      end else if (prev_req) begin
         vectors++;
         ok = acked ? (ticks_since_ack == 1)
                    : (rises_in_req == TIMEOUT && ticks_since_rise == 1);
         if (!ok) begin
            miscompares++;
            $display("FAIL req_fall: acked=%b clk_after_ack=%0d rises=%0d clk_after_rise=%0d, want 1 clk after ack or after rise %0d",
                     acked, ticks_since_ack, rises_in_req, ticks_since_rise, TIMEOUT);
         end
         req_active = 1'b0;
      end
      prev_req = (reg_req === 1'b1);

      phase     = (phase + 1) % HPER;
      HCLK_rise = (phase == 0);
      HCLK_fall = (phase == HPER / 2);
      if (HCLK_rise) begin
         master_rise();
         if (req_active && !acked) begin
            rises_in_req++;
            ticks_since_rise = 0;
         end
      end

      reg_ack   = 1'b0;
      reg_rdata = $urandom();
      if (req_active && !acked &&
          ((cur_req.ack_delay >= 0 && req_age == cur_req.ack_delay) ||
           (cur_req.ack_rise > 0 && HCLK_rise && rises_in_req == cur_req.ack_rise))) begin
         reg_ack = 1'b1;
         reg_rdata = cur_req.rdata;
         acked = 1'b1;
         ticks_since_ack = 0;
      end
      HREADY = HREADYOUT;
   endtask

   task automatic run_until_done(input string name);
      int n;
      n = 0;
      tick();
      while ((stim_q.size() > 0 || ap_valid || dp_valid || req_active) && n < 600) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 600) begin
         miscompares++;
         $display("FAIL %s_timeout: transfers still open after %0d clk, want done", name, n);
      end
      repeat (2 * HPER) tick();
      vectors++;
      if (req_q.size() != 0 || resp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_leftover: %0d requests %0d responses pending, want 0/0",
                  name, req_q.size(), resp_q.size());
      end
   endtask

   task automatic check_reset_values(input string name);
      vectors++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0 || reg_req !== 1'b0 ||
          reg_write !== 1'b0 || reg_addr !== 6'h0 || reg_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL %s: HREADYOUT=%b HRESP=%b HRDATA=%h req=%b write=%b addr=%0d wdata=%h, want 1 0 0 0 0 0 0",
                  name, HREADYOUT, HRESP, HRDATA, reg_req, reg_write, reg_addr, reg_wdata);
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (4) tick();
      check_reset_values("reset_values");
      #1 n_rst = 1'b1;
      repeat (2 * HPER) tick();
   endtask

   task automatic test_read();
      stim_q.push_back(mk(1'b0, 8'h0C, 32'h0, 32'hDEADBEEF, 2, 0, 1));
      run_until_done("read_w3");
      stim_q.push_back(mk(1'b0, 8'h3C, 32'h0, 32'h0F0F1234, 2, 0, 1));
      run_until_done("read_last_word");
   endtask

   task automatic test_write();
      // ack lands in the same clk as the first wait-state rise
      stim_q.push_back(mk(1'b1, 8'h14, 32'h12345678, 32'h0, 3, 0, 1));
      run_until_done("write_w5");
   endtask

   task automatic test_decode_err();
      stim_q.push_back(mk(1'b0, 8'h40, 32'h0, 32'h11111111, 2, 0, 1));
      run_until_done("dec_err_range");
      stim_q.push_back(mk(1'b1, 8'h02, 32'hAAAA5555, 32'h0, 2, 0, 1));
      run_until_done("dec_err_align");
   endtask

   task automatic test_timeout();
      stim_q.push_back(mk(1'b0, 8'h08, 32'h0, 32'h0, -1, 0, TIMEOUT + 1));
      run_until_done("timeout");
      stim_q.push_back(mk(1'b0, 8'h10, 32'h0, 32'h600DF00D, -1, TIMEOUT, TIMEOUT));
      run_until_done("ack_at_timeout");
   endtask

   task automatic test_back_to_back();
      stim_q.push_back(mk(1'b0, 8'h04, 32'h0, 32'hCAFE0001, 2, 0, 1));
      stim_q.push_back(mk(1'b1, 8'h08, 32'h0BADF00D, 32'h0, 1, 0, 1));
      stim_q.push_back(mk(1'b0, 8'h24, 32'h0, 32'h5A5A3C3C, 0, 0, 1));
      run_until_done("back_to_back");
   endtask

   task automatic test_reset_mid();
      int n;
      stim_q.push_back(mk(1'b1, 8'h1C, 32'h77665544, 32'h0, -1, 0, -1));
      n = 0;
      while (!req_active && n < 200) begin
         tick();
         n++;
      end
      vectors++;
      if (!req_active) begin
         miscompares++;
         $display("FAIL reset_mid_req: reg_req=%b after %0d clk, want 1", reg_req, n);
      end
      tick();
      #1 n_rst = 1'b0;
      #1 check_reset_values("reset_mid");
      stim_q.delete(); req_q.delete(); resp_q.delete();
      ap_valid = 1'b0; dp_valid = 1'b0; req_active = 1'b0; prev_req = 1'b0;
      acked = 1'b0; model_hrdata = '0;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = '0; HWDATA = '0;
      reg_ack = 1'b0; HREADY = 1'b1;
      repeat (4) tick();
      #1 n_rst = 1'b1;
      repeat (3 * HPER) tick();
      stim_q.push_back(mk(1'b0, 8'h18, 32'h0, 32'h13572468, 2, 0, 1));
      run_until_done("after_reset");
   endtask

   initial begin
      cur_req.wr = 1'b0; cur_req.idx = '0; cur_req.wdata = '0; cur_req.rdata = '0;
      cur_req.ack_delay = -1; cur_req.ack_rise = 0;
      test_reset();
      test_read();
      test_write();
      test_decode_err();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
